// File: rtl/ctrl_rx_multi.sv
// Multi-port game-controller serial receiver: per-port pin synchronisers, idle-timeout framing, field decode,
// saturating bad-frame counters and a stale-link safe state. CTRL_RX_DEBUG_EN adds raw-byte/bit-count taps.
module ctrl_rx_multi #(
   parameter int NUM_CH       = 2,
   parameter int FRAME_BITS   = 24,
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_CYCLES  = 1000,
   parameter int STALE_CYCLES = 2**22,
   parameter int ERR_W        = 8
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [NUM_CH-1:0]       chip_clk_raw,
   input  logic [NUM_CH-1:0]       chip_data_raw,
   output logic [8*NUM_CH-1:0]     buttons_out,
   output logic [8*NUM_CH-1:0]     joystick_x_out,
   output logic [8*NUM_CH-1:0]     joystick_y_out,
   output logic [NUM_CH-1:0]       frame_valid_out,
   output logic [NUM_CH-1:0]       connected_out,
   output logic [ERR_W*NUM_CH-1:0] err_count_out
`ifdef CTRL_RX_DEBUG_EN
   ,
   output logic [8*NUM_CH-1:0]     last_raw_byte_out,
   output logic [8*NUM_CH-1:0]     bit_cnt_out
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam int IDW = $clog2(IDLE_CYCLES + 1);
   localparam int STW = $clog2(STALE_CYCLES + 1);
   localparam int BCW = 8;

   // The commit decision is registered, so the timer fires one count early to land on IDLE_CYCLES.
   localparam logic [IDW-1:0] IDLE_LAST  = IDW'(IDLE_CYCLES - 2);
   localparam logic [STW-1:0] STALE_LAST = STW'(STALE_CYCLES - 1);
   localparam logic [STW-1:0] STALE_PRE  = STW'(STALE_CYCLES - 2);
   localparam logic [BCW-1:0] BC_FULL    = BCW'(FRAME_BITS);
   localparam logic [BCW-1:0] BC_SAT     = BCW'(FRAME_BITS + 1);

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] clk_sync_r;
      logic [SYNC_STAGES-1:0] data_sync_r;
      logic                   clk_prev_r;
      logic                   edge_s;
      logic                   bit_s;
      state_t                 state_r;
      state_t                 state_nxt_s;
      logic                   commit_s;
      logic                   good_s;
      logic                   bad_s;
      logic                   stale_hit_s;
      logic [FRAME_BITS-1:0]  shreg_r;
      logic [BCW-1:0]         bit_cnt_r;
      logic [IDW-1:0]         idle_cnt_r;
      logic [STW-1:0]         stale_cnt_r;
      logic [7:0]             btn_r;
      logic [7:0]             jx_r;
      logic [7:0]             jy_r;
      logic                   valid_r;
      logic                   conn_r;
      logic [ERR_W-1:0]       err_r;

      // Raw-pin synchronisers plus the previous synced clock for edge detection
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            clk_sync_r  <= {SYNC_STAGES{1'b0}};
            data_sync_r <= {SYNC_STAGES{1'b0}};
            clk_prev_r  <= 1'b0;
         end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], chip_clk_raw[ch]};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], chip_data_raw[ch]};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
         end
      end

      assign edge_s = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
      assign bit_s  = data_sync_r[SYNC_STAGES-1];

      // Frame FSM next-state; an edge on the timeout cycle keeps the frame alive
      always_comb begin
         state_nxt_s = state_r;
         commit_s    = 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (edge_s) begin
                  state_nxt_s = ST_SHIFT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (!edge_s && (idle_cnt_r == IDLE_LAST)) begin
                  state_nxt_s = ST_COMMIT;
                  commit_s    = 1'b1;
               end else begin
                  state_nxt_s = ST_SHIFT;
               end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
         endcase
      end

      assign good_s      = commit_s && (bit_cnt_r == BC_FULL);
      assign bad_s       = commit_s && (bit_cnt_r != BC_FULL);
      assign stale_hit_s = !good_s && (stale_cnt_r == STALE_PRE);

      // FSM state register
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            state_r <= ST_IDLE;
         end else begin
            state_r <= state_nxt_s;
         end
      end

      // Shift register, bit counter and idle timer
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            shreg_r    <= {FRAME_BITS{1'b0}};
            bit_cnt_r  <= {BCW{1'b0}};
            idle_cnt_r <= {IDW{1'b0}};
         end else if (state_r == ST_IDLE) begin
            if (edge_s) begin
               shreg_r    <= {shreg_r[FRAME_BITS-2:0], bit_s};
               bit_cnt_r  <= BCW'(1);
               idle_cnt_r <= {IDW{1'b0}};
            end
         end else if (state_r == ST_SHIFT) begin
            if (edge_s) begin
               shreg_r    <= {shreg_r[FRAME_BITS-2:0], bit_s};
               idle_cnt_r <= {IDW{1'b0}};
               if (bit_cnt_r != BC_SAT) begin
                  bit_cnt_r <= bit_cnt_r + BCW'(1);
               end
            end else if (!commit_s) begin
               idle_cnt_r <= idle_cnt_r + IDW'(1);
            end
         end
      end

      // Decoded outputs, link supervision and error counting
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            btn_r       <= 8'h00;
            jx_r        <= 8'h80;
            jy_r        <= 8'h80;
            valid_r     <= 1'b0;
            conn_r      <= 1'b0;
            err_r       <= {ERR_W{1'b0}};
            stale_cnt_r <= {STW{1'b0}};
         end else begin
            valid_r <= good_s;
            if (good_s) begin
               btn_r       <= shreg_r[23:16];
               jx_r        <= shreg_r[15:8];
               jy_r        <= shreg_r[7:0];
               conn_r      <= 1'b1;
               stale_cnt_r <= {STW{1'b0}};
            end else begin
               if (stale_cnt_r != STALE_LAST) begin
                  stale_cnt_r <= stale_cnt_r + STW'(1);
               end
               // Lost link: park inputs at neutral so nothing stays held down
               if (stale_hit_s) begin
                  conn_r <= 1'b0;
                  btn_r  <= 8'h00;
                  jx_r   <= 8'h80;
                  jy_r   <= 8'h80;
               end
            end
            if (bad_s && (err_r != {ERR_W{1'b1}})) begin
               err_r <= err_r + ERR_W'(1);
            end
         end
      end

      assign buttons_out[8*ch +: 8]         = btn_r;
      assign joystick_x_out[8*ch +: 8]      = jx_r;
      assign joystick_y_out[8*ch +: 8]      = jy_r;
      assign frame_valid_out[ch]            = valid_r;
      assign connected_out[ch]              = conn_r;
      assign err_count_out[ERR_W*ch +: ERR_W] = err_r;

`ifdef CTRL_RX_DEBUG_EN
      assign last_raw_byte_out[8*ch +: 8] = shreg_r[7:0];
      assign bit_cnt_out[8*ch +: 8]       = bit_cnt_r;
`else
      // Shift register and bit counter stay internal in production builds.
`endif
   end

endmodule
